// File: rtl/oled_pkg.sv
// Shared types and constants for the OLED character path (screen buffer and sequencer).
package oled_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CLEAR  = 2'd1,
        SCROLL = 2'd2
    } scrbuf_state_e;

    localparam int NB_PAGES   = 4;
    localparam int NB_LETTERS = 16;
    localparam int NB_CELLS   = NB_PAGES * NB_LETTERS;

    localparam logic [7:0] BLANK_CHAR = 8'h20;
    localparam logic [7:0] CH_CR      = 8'h0D;
    localparam logic [7:0] CH_LF      = 8'h0A;
    localparam logic [7:0] CH_BS      = 8'h08;
    localparam logic [7:0] CH_FF      = 8'h0C;

    function automatic logic is_printable(input logic [7:0] c);
        return (c >= 8'h20) && (c <= 8'h7E);
    endfunction

endpackage

// File: rtl/uart_screen_buf_if.sv
// Bundle between the UART-side producer / OLED sequencer (master) and the screen buffer (slave).
interface uart_screen_buf_if;

    logic [7:0] rx_data;
    logic       rx_valid;
    logic [1:0] rd_page;
    logic [3:0] rd_ind;
    logic [7:0] rd_char;
    logic       upd;
    logic       upd_ack;
    logic       busy;
    logic       ovf;
    logic [1:0] cur_page;
    logic [3:0] cur_ind;

    modport master (
        output rx_data, rx_valid, rd_page, rd_ind, upd_ack,
        input  rd_char, upd, busy, ovf, cur_page, cur_ind
    );

    modport slave (
        input  rx_data, rx_valid, rd_page, rd_ind, upd_ack,
        output rd_char, upd, busy, ovf, cur_page, cur_ind
    );

endinterface

// File: rtl/screen_cursor.sv
// Cursor page/index registers with advance, newline and backspace moves.
// With UART_SCREEN_SCROLL_EN the cursor parks on the last page on overflow and reports it.
module screen_cursor
    import oled_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       adv,
    input  logic       newline,
    input  logic       bksp,
    input  logic       home,
    output logic [1:0] page,
    output logic [3:0] ind,
`ifdef UART_SCREEN_SCROLL_EN
    output logic       page_ovf,
`endif
    output logic       bs_ok,
    output logic [1:0] bs_page,
    output logic [3:0] bs_ind
);

    localparam logic [1:0] LAST_PAGE = 2'(NB_PAGES - 1);
    localparam logic [3:0] LAST_IND  = 4'(NB_LETTERS - 1);
`ifdef UART_SCREEN_SCROLL_EN
    localparam logic [1:0] WRAP_PAGE = LAST_PAGE;
`else
    localparam logic [1:0] WRAP_PAGE = 2'd0;
`endif

    logic [1:0] page_reg;
    logic [3:0] ind_reg;
    logic       line_end;
    logic       ovf_hit;

    assign line_end = newline || (adv && (ind_reg == LAST_IND));
    assign ovf_hit  = line_end && (page_reg == LAST_PAGE);

    // Backspace target: previous letter, or last letter of the previous page.
    assign bs_ok   = (page_reg != 2'd0) || (ind_reg != 4'd0);
    assign bs_page = (ind_reg != 4'd0) ? page_reg : page_reg - 2'd1;
    assign bs_ind  = ind_reg - 4'd1;

`ifdef UART_SCREEN_SCROLL_EN
    assign page_ovf = ovf_hit;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            page_reg <= 2'd0;
            ind_reg  <= 4'd0;
        end else if (home) begin
            page_reg <= 2'd0;
            ind_reg  <= 4'd0;
        end else if (line_end) begin
            ind_reg  <= 4'd0;
            page_reg <= ovf_hit ? WRAP_PAGE : page_reg + 2'd1;
        end else if (adv) begin
            ind_reg <= ind_reg + 4'd1;
        end else if (bksp && bs_ok) begin
            page_reg <= bs_page;
            ind_reg  <= bs_ind;
        end
    end

    assign page = page_reg;
    assign ind  = ind_reg;

endmodule

// File: rtl/uart_screen_buf.sv
// Character screen buffer: decodes UART bytes into a 4x16 cell array read by the OLED sequencer.
// Optional UART_SCREEN_SCROLL_EN: page overflow scrolls the screen up instead of wrapping to the top.
module uart_screen_buf
    import oled_pkg::*;
(
    input logic              clk,
    input logic              rst,
    uart_screen_buf_if.slave bus
);

    localparam logic [5:0] LAST_CELL = 6'(NB_CELLS - 1);

    scrbuf_state_e state_reg;
    logic [5:0]    cnt_reg;
    logic          busy_reg;
    logic          ovf_reg;
    logic          upd_reg;
    logic [7:0]    rd_char_reg;
    logic [7:0]    pend_data_reg;
    logic          pend_valid_reg;
    logic [7:0]    mem_reg [NB_CELLS];

    logic                consume;
    logic                adv, newline, bksp, home, start_clear;
    logic                wr_en;
    logic [5:0]          wr_addr;
    logic [7:0]          wr_data;
    logic [NB_CELLS-1:0] wr_sel;
    logic [1:0]          cur_page, bs_page;
    logic [3:0]          cur_ind, bs_ind;
    logic                bs_ok;

`ifdef UART_SCREEN_SCROLL_EN
    localparam logic [5:0] SCROLL_KEEP = 6'(NB_CELLS - NB_LETTERS);
    logic       page_ovf;
    logic [5:0] scroll_src;
    assign scroll_src = cnt_reg + 6'(NB_LETTERS);
`endif

    screen_cursor u_cursor (
        .clk      (clk),
        .rst      (rst),
        .adv      (adv),
        .newline  (newline),
        .bksp     (bksp),
        .home     (home),
        .page     (cur_page),
        .ind      (cur_ind),
`ifdef UART_SCREEN_SCROLL_EN
        .page_ovf (page_ovf),
`endif
        .bs_ok    (bs_ok),
        .bs_page  (bs_page),
        .bs_ind   (bs_ind)
    );

    // The pending byte is only drained in IDLE; bulk operations leave it parked.
    assign consume = (state_reg == IDLE) && pend_valid_reg;

    always_comb begin
        adv         = 1'b0;
        newline     = 1'b0;
        bksp        = 1'b0;
        home        = 1'b0;
        start_clear = 1'b0;
        wr_en       = 1'b0;
        wr_addr     = 6'd0;
        wr_data     = BLANK_CHAR;
        case (state_reg)
            IDLE: begin
                if (pend_valid_reg) begin
                    if (is_printable(pend_data_reg)) begin
                        wr_en   = 1'b1;
                        wr_addr = {cur_page, cur_ind};
                        wr_data = pend_data_reg;
                        adv     = 1'b1;
                    end else begin
                        case (pend_data_reg)
                            CH_CR: newline = 1'b1;
                            CH_BS: begin
                                if (bs_ok) begin
                                    wr_en   = 1'b1;
                                    wr_addr = {bs_page, bs_ind};
                                    bksp    = 1'b1;
                                end
                            end
                            CH_FF: begin
                                home        = 1'b1;
                                start_clear = 1'b1;
                            end
                            CH_LF:   ;
                            default: ;
                        endcase
                    end
                end
            end
            CLEAR: begin
                wr_en   = 1'b1;
                wr_addr = cnt_reg;
            end
`ifdef UART_SCREEN_SCROLL_EN
            SCROLL: begin
                wr_en   = 1'b1;
                wr_addr = cnt_reg;
                if (cnt_reg < SCROLL_KEEP) begin
                    wr_data = mem_reg[scroll_src];
                end
            end
`endif
            default: ;
        endcase
    end

    generate
        for (genvar gi = 0; gi < NB_CELLS; gi++) begin : g_wr_sel
            assign wr_sel[gi] = wr_en && (wr_addr == 6'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < NB_CELLS; i++) begin
            if (!rst) begin
                mem_reg[i] <= BLANK_CHAR;
            end else if (wr_sel[i]) begin
                mem_reg[i] <= wr_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg      <= IDLE;
            cnt_reg        <= 6'd0;
            busy_reg       <= 1'b0;
            ovf_reg        <= 1'b0;
            upd_reg        <= 1'b0;
            rd_char_reg    <= 8'h00;
            pend_data_reg  <= 8'h00;
            pend_valid_reg <= 1'b0;
        end else begin
            if (bus.rx_valid && (!pend_valid_reg || consume)) begin
                pend_data_reg  <= bus.rx_data;
                pend_valid_reg <= 1'b1;
            end else if (consume) begin
                pend_valid_reg <= 1'b0;
            end

            if (start_clear) begin
                ovf_reg <= 1'b0;
            end else if (bus.rx_valid && pend_valid_reg && !consume) begin
                ovf_reg <= 1'b1;
            end

            // A write wins over a same-cycle acknowledge so no change is lost.
            if (wr_en) begin
                upd_reg <= 1'b1;
            end else if (bus.upd_ack) begin
                upd_reg <= 1'b0;
            end

            rd_char_reg <= mem_reg[{bus.rd_page, bus.rd_ind}];

            case (state_reg)
                IDLE: begin
                    cnt_reg <= 6'd0;
                    if (start_clear) begin
                        state_reg <= CLEAR;
                        busy_reg  <= 1'b1;
                    end
`ifdef UART_SCREEN_SCROLL_EN
                    else if (page_ovf) begin
                        state_reg <= SCROLL;
                        busy_reg  <= 1'b1;
                    end
`endif
                end
                default: begin
                    if (cnt_reg == LAST_CELL) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end
                    cnt_reg <= cnt_reg + 6'd1;
                end
            endcase
        end
    end

    assign bus.rd_char  = rd_char_reg;
    assign bus.upd      = upd_reg;
    assign bus.busy     = busy_reg;
    assign bus.ovf      = ovf_reg;
    assign bus.cur_page = cur_page;
    assign bus.cur_ind  = cur_ind;

endmodule

// File: tb/tb_uart_screen_buf.sv
// Self-checking bench for uart_screen_buf: cycle model plus directed test-plan vectors.
// Expectations follow UART_SCREEN_SCROLL_EN when it is defined.
module tb_uart_screen_buf;

    logic clk;
    logic rst;
    uart_screen_buf_if bus();

    uart_screen_buf dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] m_mem [64];
    int         m_page, m_ind, m_busy_left;
    bit         m_pend_v, m_upd, m_ovf, m_rd_valid, m_scroll_op;
    logic [7:0] m_pend, m_rd;

    task automatic m_reset();
        for (int i = 0; i < 64; i++) m_mem[i] = 8'h20;
        m_page = 0; m_ind = 0; m_busy_left = 0;
        m_pend_v = 0; m_pend = 8'h00; m_upd = 0; m_ovf = 0;
        m_rd = 8'h00; m_rd_valid = 1; m_scroll_op = 0;
    endtask

    task automatic m_newline();
        m_ind = 0;
        if (m_page == 3) begin
`ifdef UART_SCREEN_SCROLL_EN
            m_page = 3; m_busy_left = 64; m_scroll_op = 1;
`else
            m_page = 0;
`endif
        end else begin
            m_page++;
        end
    endtask

    task automatic m_finish_op();
        if (m_scroll_op) begin
            for (int k = 0; k < 48; k++) m_mem[k] = m_mem[k + 16];
            for (int k = 48; k < 64; k++) m_mem[k] = 8'h20;
        end else begin
            for (int k = 0; k < 64; k++) m_mem[k] = 8'h20;
        end
    endtask

    task automatic m_step();
        bit consume, wrote;
        logic [7:0] b;
        if (rst == 1'b0) begin
            m_reset();
            return;
        end
        m_rd_valid = (m_busy_left == 0);
        m_rd       = m_mem[int'(bus.rd_page) * 16 + int'(bus.rd_ind)];
        consume    = (m_busy_left == 0) && m_pend_v;
        wrote      = 0;
        if (m_busy_left > 0) begin
            wrote = 1;
            m_busy_left--;
            if (m_busy_left == 0) m_finish_op();
        end else if (consume) begin
            b = m_pend;
            if (b >= 8'h20 && b <= 8'h7E) begin
                m_mem[m_page * 16 + m_ind] = b;
                wrote = 1;
                if (m_ind == 15) m_newline(); else m_ind++;
            end else if (b == 8'h0D) begin
                m_newline();
            end else if (b == 8'h08) begin
                if (m_ind > 0 || m_page > 0) begin
                    if (m_ind > 0) m_ind--;
                    else begin m_page--; m_ind = 15; end
                    m_mem[m_page * 16 + m_ind] = 8'h20;
                    wrote = 1;
                end
            end else if (b == 8'h0C) begin
                m_page = 0; m_ind = 0; m_ovf = 0;
                m_busy_left = 64; m_scroll_op = 0;
            end
        end
        if (bus.rx_valid) begin
            if (!m_pend_v || consume) begin
                m_pend = bus.rx_data; m_pend_v = 1;
            end else begin
                m_ovf = 1;
            end
        end else if (consume) begin
            m_pend_v = 0;
        end
        if (wrote) m_upd = 1;
        else if (bus.upd_ack) m_upd = 0;
    endtask

    initial forever begin
        @(posedge clk);
        m_step();
    end

    // Per-cycle comparison; rd_char is only defined when the sampled contents were stable.
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", {31'd0, bus.busy}, {31'd0, m_busy_left != 0});
            check("ovf", {31'd0, bus.ovf}, {31'd0, m_ovf});
            check("upd", {31'd0, bus.upd}, {31'd0, m_upd});
            check("cur_page", {30'd0, bus.cur_page}, 32'(m_page));
            check("cur_ind", {28'd0, bus.cur_ind}, 32'(m_ind));
            if (m_rd_valid) check("rd_char", {24'd0, bus.rd_char}, {24'd0, m_rd});
        end
    end

    int busy_run = 0;
    int last_busy_run = 0;
    always @(negedge clk) begin
        if (bus.busy) busy_run++;
        else if (busy_run != 0) begin
            last_busy_run = busy_run;
            busy_run = 0;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        $display("rx byte 0x%02h at t=%0t", b, $time);
        tick();
        bus.rx_valid = 1'b0;
    endtask

    task automatic ack();
        bus.upd_ack = 1'b1;
        tick();
        bus.upd_ack = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        repeat (2) tick();
        while (bus.busy && n < 200) begin
            tick();
            n++;
        end
        check("busy_timeout", {31'd0, bus.busy}, 32'd0);
        repeat (2) tick();
    endtask

    task automatic read_lit(input string name, input int p, input int i, input logic [7:0] exp);
        bus.rd_page = 2'(p);
        bus.rd_ind  = 4'(i);
        tick();
        check(name, {24'd0, bus.rd_char}, {24'd0, exp});
    endtask

    task automatic check_cur(input string name, input int p, input int i);
        check(name, {26'd0, bus.cur_page, bus.cur_ind}, 32'(p * 16 + i));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed test plan ----------------
    initial begin
        logic [7:0] exp;
        int n;
        rst = 1'b0;
        bus.rx_data = 8'h00; bus.rx_valid = 1'b0;
        bus.rd_page = 2'd0;  bus.rd_ind = 4'd0; bus.upd_ack = 1'b0;
        repeat (3) tick();
        check("reset_rd_char", {24'd0, bus.rd_char}, 32'h00);
        check("reset_upd", {31'd0, bus.upd}, 32'd0);
        check("reset_busy", {31'd0, bus.busy}, 32'd0);
        check("reset_ovf", {31'd0, bus.ovf}, 32'd0);
        check_cur("reset_cursor", 0, 0);
        rst = 1'b1;
        chk_en = 1;

        // Two printable bytes, then acknowledge
        send(8'h41); send(8'h42);
        repeat (2) tick();
        check_cur("ab_cursor", 0, 2);
        check("ab_upd", {31'd0, bus.upd}, 32'd1);
        read_lit("ab_cell00", 0, 0, 8'h41);
        read_lit("ab_cell01", 0, 1, 8'h42);
        ack();
        check("ab_upd_ack", {31'd0, bus.upd}, 32'd0);

        // 17 x 'X' from home, with an acknowledge colliding with a write
        send(8'h0C); wait_idle();
        for (int i = 0; i < 17; i++) begin
            bus.upd_ack = (i == 5);
            send(8'h58);
        end
        bus.upd_ack = 1'b0;
        repeat (2) tick();
        check_cur("x17_cursor", 1, 1);
        check("x17_upd", {31'd0, bus.upd}, 32'd1);
        for (int i = 0; i < 16; i++) read_lit("x17_row0", 0, i, 8'h58);
        read_lit("x17_cell10", 1, 0, 8'h58);
        read_lit("x17_cell11", 1, 1, 8'h20);
        send(8'h0D); repeat (2) tick();
        check_cur("cr_cursor", 2, 0);

        // Backspace across a page boundary
        send(8'h0C); wait_idle();
        for (int i = 0; i < 16; i++) send(8'h41);
        repeat (2) tick();
        check_cur("bs_pre_cursor", 1, 0);
        ack();
        send(8'h08); repeat (2) tick();
        check_cur("bs_cursor", 0, 15);
        check("bs_upd", {31'd0, bus.upd}, 32'd1);
        read_lit("bs_cell015", 0, 15, 8'h20);
        read_lit("bs_cell014", 0, 14, 8'h41);

        // Backspace at origin and LF: no effect, no update
        send(8'h0C); wait_idle(); ack();
        send(8'h08); send(8'h0A); repeat (2) tick();
        check_cur("bs0_cursor", 0, 0);
        check("bs0_upd", {31'd0, bus.upd}, 32'd0);

        // FF then a byte one cycle later: held through CLEAR
        send(8'h0C); send(8'h43); wait_idle();
        check("ff_busy_len", 32'(last_busy_run), 32'd64);
        check("ff_ovf", {31'd0, bus.ovf}, 32'd0);
        for (int i = 0; i < 64; i++) begin
            exp = (i == 0) ? 8'h43 : 8'h20;
            read_lit("ff_cells", i / 16, i % 16, exp);
        end

        // A further byte during CLEAR is dropped
        send(8'h0C); send(8'h44); send(8'h45); wait_idle();
        check("drop_busy_len", 32'(last_busy_run), 32'd64);
        check("drop_ovf", {31'd0, bus.ovf}, 32'd1);
        read_lit("drop_cell00", 0, 0, 8'h44);
        read_lit("drop_cell01", 0, 1, 8'h20);
        check_cur("drop_cursor", 0, 1);

        // Fill the screen then overflow
        send(8'h0C); wait_idle();
        for (int i = 0; i < 64; i++) send(8'h30 + 8'(i / 16));
        send(8'h5A); wait_idle();
        for (int i = 0; i < 64; i++) begin
`ifdef UART_SCREEN_SCROLL_EN
            if (i < 48) exp = 8'h31 + 8'(i / 16);
            else exp = (i == 48) ? 8'h5A : 8'h20;
`else
            exp = (i == 0) ? 8'h5A : 8'h30 + 8'(i / 16);
`endif
            read_lit("fill_cells", i / 16, i % 16, exp);
        end
`ifdef UART_SCREEN_SCROLL_EN
        check_cur("fill_cursor", 3, 1);
`else
        check_cur("fill_cursor", 0, 1);
`endif

        // Reset during the 10th cycle of CLEAR
        send(8'h0C);
        n = 0;
        while (!bus.busy && n < 10) begin tick(); n++; end
        check("rst_busy_rise", {31'd0, bus.busy}, 32'd1);
        send(8'h61); send(8'h62);
        check("rst_pre_ovf", {31'd0, bus.ovf}, 32'd1);
        repeat (7) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_ovf", {31'd0, bus.ovf}, 32'd0);
        check("rst_upd", {31'd0, bus.upd}, 32'd0);
        check("rst_rd_char", {24'd0, bus.rd_char}, 32'h00);
        check_cur("rst_cursor", 0, 0);
        repeat (3) tick();
        check_cur("rst_cursor_held", 0, 0);
        for (int i = 0; i < 64; i++) read_lit("rst_cells", i / 16, i % 16, 8'h20);

        tick();
        chk_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_screen_buf.md
# uart_screen_buf

Character screen buffer between the UART receiver and the OLED page/column sequencer. Accepts ASCII bytes from the receiver, interprets a small set of control codes, and maintains a 4-page × 16-letter character array with a cursor. The sequencer reads characters through a registered random-access port and uses an update flag to decide when to redraw.

## Interface
- `BLANK_CHAR`, 8'h20: fill code written by clear, scroll and backspace.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `rx_data`  in  8  received byte.
- `rx_valid`  in  1  one-cycle strobe; `rx_data` is valid while it is high.
- `rd_page`  in  2  read page, 0–3.
- `rd_ind`  in  4  read letter index, 0–15.
- `rd_char`  out  8  character at {`rd_page`,`rd_ind`}; registered.
- `upd`  out  1  buffer changed since the last acknowledge.
- `upd_ack`  in  1  one-cycle pulse from the sequencer at frame done; clears `upd`.
- `busy`  out  1  high in CLEAR or SCROLL.
- `ovf`  out  1  sticky; a byte was dropped.
- `cur_page`  out  2  cursor page. `cur_ind`  out  4  cursor letter index.

## Operation
- Storage is a 64-entry flop array of 8 bits each, indexed {page,ind}. Reset fills it with `BLANK_CHAR`.
- Pending register: 8-bit data plus a valid bit. It loads on `rx_valid` when empty, or when it is being consumed in the same cycle.
- If `rx_valid` arrives while the register is full and not being consumed, the byte is dropped and `ovf` is set.
- The FSM has three states:
  - IDLE: consumes the pending byte, one per cycle.
  - CLEAR: writes `BLANK_CHAR` to cells 0..63, one per cycle, for 64 cycles, then returns to IDLE.
  - SCROLL: copies cell k+16 to cell k for k=0..47, then writes `BLANK_CHAR` to cells 48..63, one per cycle, for 64 cycles, then returns to IDLE.
- Byte decode in IDLE:
  - 0x20–0x7E: write the byte at the cursor, then advance the cursor. The index wraps 15→0 and increments the page.
  - 0x0D (CR): index←0, page+1.
  - 0x08 (BS):
    - index>0: index−1, then write `BLANK_CHAR` there.
    - index=0 and page>0: page−1, index 15, then write `BLANK_CHAR` there.
    - At (0,0): no operation.
  - 0x0C (FF): cursor←(0,0), `ovf`←0, enter CLEAR.
  - 0x0A and all other codes: ignored. No change, and `upd` is not set.
- Page overflow happens when the page would increment past 3. Behaviour is set by the Configuration section.
- `upd` is set by every cell write, clear or scroll. It is cleared by `upd_ack`. If a set and `upd_ack` occur in the same cycle, `upd` stays 1.
- Reading during CLEAR or SCROLL returns the current, partially updated contents. The sequencer starts a frame only when `upd`=1 and `busy`=0.

## Timing
- Reset values: `rd_char`=8'h00, `upd`=0, `busy`=0, `ovf`=0, cursor (0,0), pending register empty, state IDLE.
- `rx_valid` at cycle n: the byte is in the pending register at n+1, its cell is written at n+2, and `rd_char` reflects it for a read issued at n+2 or later.
- Sustained printable input is accepted at 1 byte/cycle with no drops.
- In CLEAR or SCROLL the pending register is not consumed. The next byte is held in it; a further byte is dropped and sets `ovf`.
- `busy` rises the cycle after the FF byte (or the overflowing byte) is consumed, and stays high for exactly 64 cycles.
- `rd_char` latency is 1 cycle from `rd_page`/`rd_ind`.
- Reset asserted mid-CLEAR or mid-SCROLL: the next cycle shows the full reset state. No partial operation resumes.

## Configuration
- `UART_SCREEN_SCROLL_EN` defined: page overflow sets the cursor to (3,0) and enters SCROLL.
- Not defined: page overflow wraps the cursor to (0,0) with no data movement; the SCROLL state and its counter are not compiled in, and `busy` reflects CLEAR only.

## Structure
- Shared package `oled_pkg` holds:
  - state enum `scrbuf_state_e` (IDLE, CLEAR, SCROLL);
  - constants NB_PAGES=4, NB_LETTERS=16;
  - codes CH_CR=8'h0D, CH_LF=8'h0A, CH_BS=8'h08, CH_FF=8'h0C.
- One sub-module, `screen_cursor`. It holds the page/index registers and the advance, newline and backspace logic, and outputs the overflow and backspace-target signals.

## Test plan
- Bytes 0x41, 0x42 → cells (0,0)=0x41 and (0,1)=0x42; cursor (0,2); `upd`=1. Then `upd_ack` → `upd`=0.
- 17 bytes of 0x58 → row 0 all 0x58, (1,0)=0x58, cursor (1,1). CR → cursor (2,0).
- Cursor at (1,0), BS → (0,15)=0x20, cursor (0,15). BS at (0,0) → no change, `upd` stays 0.
- FF, then 0x43 one cycle later → `busy` high for 64 cycles, all cells 0x20, then (0,0)=0x43, `ovf`=0. A third byte sent during `busy` → dropped, `ovf`=1.
- Fill 64 bytes 0x30+page, then 0x5A:
  - with SCROLL_EN: rows read 0x31, 0x32, 0x33, and row 3 is 0x5A followed by fifteen 0x20.
  - without: (0,0)=0x5A, rest unchanged.
- Reset (low) in the 10th cycle of CLEAR → all cells 0x20, `busy`=0, cursor (0,0), `ovf`=0 next cycle.
